// File: rtl/i2s_pkg.sv
// Shared types and parameter helpers for the I2S transmit stream.
// Used by i2s_clk_gen and i2s_tx_stream.
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam int DEF_FRAME = 512;

   function automatic int frame_len(input int slot_w, input int sck_div);
      return 2 * slot_w * sck_div;
   endfunction

   function automatic int fcnt_w(input int slot_w, input int sck_div);
      return $clog2(frame_len(slot_w, sck_div));
   endfunction

   function automatic bit params_ok(input int sample_w, input int slot_w,
                                    input int sck_div, input int mclk_div,
                                    input int cnt_w);
      return (sample_w >= 1) && (sample_w <= slot_w) &&
             (sck_div >= 4) && (sck_div % 2 == 0) &&
             (mclk_div >= 2) && (mclk_div % 2 == 0) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Frame counter plus registered MCLK/SCK/LRCK generation for i2s_tx_stream.
// Strobes flag the edge on which the counter enters a new bit or a new frame.
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int SLOT_W   = 16,
   parameter int SCK_DIV  = 16,
   parameter int MCLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic run_nxt,
   output logic fcnt_wrap,
   output logic bit_strobe,
   output logic frame_strobe,
   output logic audio_mclk,
   output logic audio_sck,
   output logic audio_lrck
);

   localparam int FRAME = frame_len(SLOT_W, SCK_DIV);
   localparam int FW    = fcnt_w(SLOT_W, SCK_DIV);
   localparam int MW    = $clog2(MCLK_DIV);

   localparam logic [FW-1:0] LAST      = FW'(FRAME - 1);
   localparam logic [FW-1:0] SCK_DIV_F = FW'(SCK_DIV);
   localparam logic [FW-1:0] SCK_HALF  = FW'(SCK_DIV / 2);
   localparam logic [FW-1:0] RSLOT     = FW'(SLOT_W * SCK_DIV);
   localparam logic [MW-1:0] M_LAST    = MW'(MCLK_DIV / 2 - 1);

   logic [FW-1:0] fcnt, fcnt_nxt;
   logic [MW-1:0] mcnt;

   assign fcnt_wrap = (fcnt == LAST);

   // The entry cycle from IDLE leaves fcnt at 0, so frame 0 starts on that edge.
   always_comb begin
      fcnt_nxt = '0;
      if (run_nxt && active && !fcnt_wrap)
         fcnt_nxt = fcnt + 1'b1;
   end

   assign frame_strobe = run_nxt && (!active || fcnt_wrap);
   assign bit_strobe   = run_nxt && ((fcnt_nxt % SCK_DIV_F) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt       <= '0;
         mcnt       <= '0;
         audio_mclk <= 1'b0;
         audio_sck  <= 1'b0;
         audio_lrck <= 1'b0;
      end else begin
         fcnt       <= fcnt_nxt;
         audio_sck  <= run_nxt && ((fcnt_nxt % SCK_DIV_F) >= SCK_HALF);
         audio_lrck <= run_nxt && (fcnt_nxt >= RSLOT);
         if (!run_nxt) begin
            mcnt       <= '0;
            audio_mclk <= 1'b0;
         end else if (active) begin
            if (mcnt == M_LAST) begin
               mcnt       <= '0;
               audio_mclk <= ~audio_mclk;
            end else begin
               mcnt <= mcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/i2s_tx_stream.sv
// Parametrised I2S transmitter: 1-deep sample buffer, run/stop FSM, shifter, underrun count.
// Define I2S_STD_EN for Philips timing (data lags LRCK by one SCK); default is left-justified.
module i2s_tx_stream
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int SLOT_W   = 16,
   parameter int SCK_DIV  = 16,
   parameter int MCLK_DIV = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mute,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                audio_mclk,
   output logic                audio_lrck,
   output logic                audio_sck,
   output logic                audio_sdin,
   output logic                underrun,
   output logic [CNT_W-1:0]    underrun_cnt,
   output logic                running
);

   localparam int WW  = 2 * SLOT_W;
   localparam int PAD = SLOT_W - SAMPLE_W;

   if (!params_ok(SAMPLE_W, SLOT_W, SCK_DIV, MCLK_DIV, CNT_W)) begin : g_param_check
      $error("i2s_tx_stream: illegal parameter set");
   end

   state_t state, state_nxt;
   logic active, run_nxt, fcnt_wrap, bit_strobe, frame_strobe;
   logic buf_full, xfer, first_bit, next_bit;
   logic [SAMPLE_W-1:0] buf_left, buf_right;
   logic [WW-1:0] shifter, load_word;

   i2s_clk_gen #(
      .SLOT_W   (SLOT_W),
      .SCK_DIV  (SCK_DIV),
      .MCLK_DIV (MCLK_DIV)
   ) u_clk_gen (
      .clk          (clk),
      .rst          (rst),
      .active       (active),
      .run_nxt      (run_nxt),
      .fcnt_wrap    (fcnt_wrap),
      .bit_strobe   (bit_strobe),
      .frame_strobe (frame_strobe),
      .audio_mclk   (audio_mclk),
      .audio_sck    (audio_sck),
      .audio_lrck   (audio_lrck)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // STOP always runs to the frame end; en seen at the wrap decides RUN vs IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = STOP;
         STOP:    if (fcnt_wrap) state_nxt = en ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign active  = (state != IDLE);
   assign run_nxt = (state_nxt != IDLE);
   assign running = active;
   assign s_ready = !buf_full;
   assign xfer    = s_valid && s_ready;

   always_comb begin
      load_word = '0;
      if (buf_full && !mute)
         load_word = {SLOT_W'(buf_left) << PAD, SLOT_W'(buf_right) << PAD};
   end

`ifdef I2S_STD_EN
   assign first_bit = shifter[WW-1];
   assign next_bit  = shifter[WW-1];
`else
   assign first_bit = load_word[WW-1];
   assign next_bit  = shifter[WW-2];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full     <= 1'b0;
         buf_left     <= '0;
         buf_right    <= '0;
         shifter      <= '0;
         audio_sdin   <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun <= frame_strobe && !buf_full;
         if (frame_strobe && !buf_full && (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + 1'b1;
         // A boundary transfer into an empty buffer is kept for the next frame.
         if (xfer) begin
            buf_full  <= 1'b1;
            buf_left  <= s_left;
            buf_right <= s_right;
         end else if (frame_strobe) begin
            buf_full <= 1'b0;
         end
         if (!run_nxt) begin
            shifter    <= '0;
            audio_sdin <= 1'b0;
         end else if (frame_strobe) begin
            shifter    <= load_word;
            audio_sdin <= first_bit;
         end else if (bit_strobe) begin
            shifter    <= shifter << 1;
            audio_sdin <= next_bit;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Self-checking bench for i2s_tx_stream: a default instance and a 12-bit/CNT_W=2 instance
// share control and are checked bit by bit against slot arithmetic derived from frame timing.
module tb_i2s_tx_stream;

   localparam int FRAME = 512;
   localparam int SCK   = 16;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, mute = 1'b0, s_valid = 1'b0;
   logic [15:0] s_left_a = '0, s_right_a = '0;
   logic [11:0] s_left_b = '0, s_right_b = '0;
   logic s_ready_a, mclk_a, lrck_a, sck_a, sdin_a, underrun_a, running_a;
   logic s_ready_b, mclk_b, lrck_b, sck_b, sdin_b, underrun_b, running_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int n_asserts = 0, n_fail = 0;
   int cyc = 0, t0 = 0;
   int ur_seen_a = 0, ur_seen_b = 0, exp_ur = 0, exp_cnt = 0;
   logic [15:0] nal, nar;
   logic [11:0] nbl, nbr;

   i2s_tx_stream u_dut_a (
      .clk(clk), .rst(rst), .en(en), .mute(mute),
      .s_left(s_left_a), .s_right(s_right_a), .s_valid(s_valid), .s_ready(s_ready_a),
      .audio_mclk(mclk_a), .audio_lrck(lrck_a), .audio_sck(sck_a), .audio_sdin(sdin_a),
      .underrun(underrun_a), .underrun_cnt(cnt_a), .running(running_a)
   );

   i2s_tx_stream #(.SAMPLE_W(12), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .mute(mute),
      .s_left(s_left_b), .s_right(s_right_b), .s_valid(s_valid), .s_ready(s_ready_b),
      .audio_mclk(mclk_b), .audio_lrck(lrck_b), .audio_sck(sck_b), .audio_sdin(sdin_b),
      .underrun(underrun_b), .underrun_cnt(cnt_b), .running(running_b)
   );

   // clock / reset block and free-running cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (underrun_a === 1'b1) ur_seen_a <= ur_seen_a + 1;
      if (underrun_b === 1'b1) ur_seen_b <= ur_seen_b + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pair(input logic [15:0] l, input logic [15:0] r, input int sw);
      logic [15:0] lw, rw;
      lw = l << (16 - sw);
      rw = r << (16 - sw);
      return {lw, rw};
   endfunction

   // driver tasks
   task automatic push();
      s_left_a  = nal;
      s_right_a = nar;
      s_left_b  = nbl;
      s_right_b = nbr;
      s_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic at_fcnt(input int f, input int p);
      int target;
      target = t0 + f * FRAME + p;
      if (cyc > target) begin
         n_asserts++;
         n_fail++;
         $error("FAIL sched: cycle %0d passed required %0d", cyc, target);
      end
      while (cyc < target) @(negedge clk);
   endtask

   task automatic run_start();
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      t0 = cyc;
      chk("running", {running_a, running_b}, 2'b11);
   endtask

   task automatic do_act(input int f, input int act, input int p);
      at_fcnt(f, p);
      if (act == 1) push();
      else if (act == 2) en = 1'b0;
   endtask

   // act: 0 none, 1 push next sample at fcnt act_p, 2 drop en at fcnt act_p
   task automatic check_frame(input int f, input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input bit ur, input int act, input int act_p,
                              input bit mute_next, input string tag);
      logic [31:0] ga0, ga1, gb0, gb1;
      int bad, p, n, off;
      bit pending, e_sck, e_lr, e_m;
      ga0 = '0; ga1 = '0; gb0 = '0; gb1 = '0;
      bad = 0;
      pending = (act != 0);
      for (int k = 0; k < 32; k++) begin
         for (int j = 0; j < 4; j++) begin
            off = (j == 0) ? 1 : (j == 1) ? 7 : (j == 2) ? 8 : 15;
            p = k * SCK + off;
            if (pending && act_p < p) begin
               do_act(f, act, act_p);
               pending = 1'b0;
            end
            at_fcnt(f, p);
            n = cyc - t0;
            e_sck = (off >= SCK / 2);
            e_lr  = (p >= FRAME / 2);
            e_m   = ((n / 2) % 2) == 1;
            if ({mclk_a, sck_a, lrck_a} !== {e_m, e_sck, e_lr}) bad++;
            if ({mclk_b, sck_b, lrck_b} !== {e_m, e_sck, e_lr}) bad++;
            if (j == 0) begin
               ga0 = {ga0[30:0], sdin_a};
               gb0 = {gb0[30:0], sdin_b};
            end
            if (j == 3) begin
               ga1 = {ga1[30:0], sdin_a};
               gb1 = {gb1[30:0], sdin_b};
            end
         end
      end
      if (ur) begin
         exp_ur++;
         exp_cnt++;
      end
      chk({tag, "_clocks"}, bad, 0);
`ifdef I2S_STD_EN
      chk({tag, "_a_lo"}, ga0[30:0], exp_a[31:1]);
      chk({tag, "_a_hi"}, ga1[30:0], exp_a[31:1]);
      chk({tag, "_b_lo"}, gb0[30:0], exp_b[31:1]);
      chk({tag, "_b_hi"}, gb1[30:0], exp_b[31:1]);
`else
      chk({tag, "_a_lo"}, ga0, exp_a);
      chk({tag, "_a_hi"}, ga1, exp_a);
      chk({tag, "_b_lo"}, gb0, exp_b);
      chk({tag, "_b_hi"}, gb1, exp_b);
`endif
      chk({tag, "_ur_a"}, ur_seen_a, exp_ur);
      chk({tag, "_ur_b"}, ur_seen_b, exp_ur);
      chk({tag, "_cnt_a"}, cnt_a, exp_cnt);
      chk({tag, "_cnt_b"}, cnt_b, (exp_cnt > 3) ? 3 : exp_cnt);
      mute = mute_next;
      if (pending) do_act(f, act, act_p);
   endtask

   initial begin : stimulus
      logic [15:0] a1l, a1r, a2l, a2r, a3l, a3r;
      logic [11:0] b1l, b1r, b2l, b2r, b3l, b3r;
      a1l = 16'($urandom); a1r = 16'($urandom); a2l = 16'($urandom);
      a2r = 16'($urandom); a3l = 16'($urandom); a3r = 16'($urandom);
      b1l = 12'($urandom_range(0, 4095)); b1r = 12'($urandom_range(0, 4095));
      b2l = 12'($urandom_range(0, 4095)); b2r = 12'($urandom_range(0, 4095));
      b3l = 12'($urandom_range(0, 4095)); b3r = 12'($urandom_range(0, 4095));

      // reset state
      @(negedge clk);
      chk("rst_a", {s_ready_a, mclk_a, lrck_a, sck_a, sdin_a, underrun_a, running_a, cnt_a},
          {1'b1, 6'b0, 16'h0});
      chk("rst_b", {s_ready_b, mclk_b, lrck_b, sck_b, sdin_b, underrun_b, running_b, cnt_b},
          {1'b1, 6'b0, 2'h0});
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_a", {s_ready_a, mclk_a, lrck_a, sck_a, sdin_a, running_a}, 6'b100000);

      // prefill in IDLE
      nal = 16'hA5C3; nar = 16'h3C5A; nbl = 12'hFFF; nbr = 12'h800;
      push();
      chk("prefill_ready", {s_ready_a, s_ready_b}, 2'b00);

      run_start();
      nal = a1l; nar = a1r; nbl = b1l; nbr = b1r;
      check_frame(0, 32'hA5C3_3C5A, 32'hFFF0_8000, 1'b0, 1, 511, 1'b0, "f0");
      check_frame(1, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "f1_underrun");
      chk("f1_buf_held", {s_ready_a, s_ready_b}, 2'b00);
      nal = a2l; nar = a2r; nbl = b2l; nbr = b2r;
      check_frame(2, pair(a1l, a1r, 16), pair({4'h0, b1l}, {4'h0, b1r}, 12),
                  1'b0, 1, 162, 1'b1, "f2");
      check_frame(3, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, "f3_mute");
      chk("f3_consumed", {s_ready_a, s_ready_b}, 2'b11);
      check_frame(4, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "f4_ur");
      check_frame(5, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "f5_ur");
      check_frame(6, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "f6_ur");
      nal = a3l; nar = a3r; nbl = b3l; nbr = b3r;
      check_frame(7, 32'h0, 32'h0, 1'b1, 1, 330, 1'b0, "f7_ur");
      check_frame(8, pair(a3l, a3r, 16), pair({4'h0, b3l}, {4'h0, b3r}, 12),
                  1'b0, 2, 100, 1'b0, "f8_stop");

      // after the stopped frame completes
      at_fcnt(9, 0);
      chk("stop_idle_a", {mclk_a, lrck_a, sck_a, sdin_a, underrun_a, running_a, s_ready_a}, 7'b1);
      chk("stop_idle_b", {mclk_b, lrck_b, sck_b, sdin_b, underrun_b, running_b, s_ready_b}, 7'b1);
      chk("stop_cnt_a", cnt_a, 5);
      chk("stop_cnt_b", cnt_b, 3);

      // second run: prefill, then asynchronous reset mid-frame
      nal = a2r; nar = a2l; nbl = b2r; nbr = b2l;
      push();
      run_start();
      at_fcnt(0, 300);
      rst = 1'b1;
      en  = 1'b0;
      #1;
      chk("arst_a", {s_ready_a, mclk_a, lrck_a, sck_a, sdin_a, underrun_a, running_a, cnt_a},
          {1'b1, 6'b0, 16'h0});
      chk("arst_b", {s_ready_b, mclk_b, lrck_b, sck_b, sdin_b, underrun_b, running_b, cnt_b},
          {1'b1, 6'b0, 2'h0});
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      run_start();
      check_frame(0, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "r2_discard");
      en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
